// File: rtl/sum_accumulator8.sv
// Accumulates {cout_in, sum_in} samples from the adder stage and streams a snapshot
// of the totals byte-wise on request. Define ACC_SATURATE_EN to clamp acc instead of wrapping.
module sum_accumulator8 #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       sum_in,
  input  logic             cout_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  input  logic             dump,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  output logic             out_last,
  output logic             ovf,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam int NB    = ACC_W / 8;
  localparam int IDX_W = $clog2(NB + 1);

  typedef enum logic {ACCUM, DUMP} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_add;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   shadow_acc_q, shadow_acc_d;
  logic [CNT_W-1:0]   shadow_cnt_q, shadow_cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         out_byte_q, out_byte_d, dump_byte;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [ACC_W:0]     acc_sum;
  logic               transfer;

  assign in_ready   = (state_q == ACCUM);
  assign transfer   = in_valid && in_ready && !clear;
  assign acc_sum    = {1'b0, acc_q} + (ACC_W + 1)'({cout_in, sum_in});

`ifdef ACC_SATURATE_EN
  assign acc_add = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
`else
  assign acc_add = acc_sum[ACC_W-1:0];
`endif

  // Live totals: clear beats a same-cycle transfer, in either state.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (transfer) begin
      acc_d = acc_add;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      if (acc_sum[ACC_W]) ovf_d = 1'b1;
    end
  end

  // Byte selected from the snapshot; index NB is the count byte.
  always_comb begin
    dump_byte = 8'(shadow_cnt_q);
    for (int i = 0; i < NB; i++) begin
      if (idx_q == IDX_W'(i)) dump_byte = shadow_acc_q[i*8 +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    shadow_acc_d = shadow_acc_q;
    shadow_cnt_d = shadow_cnt_q;
    idx_d        = idx_q;
    out_byte_d   = out_byte_q;
    out_valid_d  = 1'b0;
    out_last_d   = 1'b0;
    case (state_q)
      ACCUM: begin
        if (dump && !clear) begin
          // Snapshot includes a sample accepted in this same cycle; byte 0 goes out now.
          state_d      = DUMP;
          shadow_acc_d = acc_d;
          shadow_cnt_d = cnt_d;
          out_byte_d   = acc_d[7:0];
          out_valid_d  = 1'b1;
          idx_d        = IDX_W'(1);
        end
      end
      DUMP: begin
        if (out_last_q) begin
          state_d = ACCUM;
        end else begin
          out_byte_d  = dump_byte;
          out_valid_d = 1'b1;
          out_last_d  = (idx_q == IDX_W'(NB));
          idx_d       = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: the snapshot registers are reset along with everything else so the
  // stream never carries X even though they are only read after a capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACCUM;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      shadow_acc_q <= '0;
      shadow_cnt_q <= '0;
      idx_q        <= '0;
      out_byte_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      shadow_acc_q <= shadow_acc_d;
      shadow_cnt_q <= shadow_cnt_d;
      idx_q        <= idx_d;
      out_byte_q   <= out_byte_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
    end
  end

  assign out_byte   = out_byte_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign ovf        = ovf_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_sum_accumulator8.sv
// Self-checking bench for sum_accumulator8: directed scenarios plus randomized traffic
// compared against an arithmetic model of the accumulator, counter and dump stream.
module tb_sum_accumulator8;

  localparam int     ACC_W   = 16;
  localparam int     CNT_W   = 8;
  localparam int     NB      = ACC_W / 8;
  localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;
  localparam int     CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       sum_in = '0;
  logic             cout_in = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             clear = 1'b0;
  logic             dump = 1'b0;
  logic [7:0]       out_byte;
  logic             out_valid;
  logic             out_last;
  logic             ovf;
  logic [CNT_W-1:0] sample_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  longint m_acc = 0;
  int     m_cnt = 0;
  bit     m_ovf = 1'b0;

  sum_accumulator8 #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sum_in     (sum_in),
    .cout_in    (cout_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .clear      (clear),
    .dump       (dump),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .ovf        (ovf),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_clear();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endfunction

  function automatic void m_xfer(input int s);
    longint t;
    t = m_acc + longint'(s);
    if (t > ACC_MAX) begin
      m_ovf = 1'b1;
`ifdef ACC_SATURATE_EN
      m_acc = ACC_MAX;
`else
      m_acc = t - ACC_MAX - 1;
`endif
    end else begin
      m_acc = t;
    end
    if (m_cnt < CNT_MAX) m_cnt++;
  endfunction

  task automatic drive_sample(input int s);
    {cout_in, sum_in} = 9'(s);
  endtask

  // One ACCUM-state cycle with optional sample and clear.
  task automatic accum(input bit v, input int s, input bit clr);
    in_valid = v;
    drive_sample(s);
    clear = clr;
    dump  = 1'b0;
    step();
    if (clr) m_clear();
    else if (v) m_xfer(s);
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic check_totals(input string tag);
    check({tag, ".cnt"}, 32'(sample_cnt), 32'(m_cnt));
    check({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
  endtask

  // Full dump with optional same-cycle sample and a clear in dump cycle clear_at (0 = none).
  // in_valid is held high through the dump to confirm nothing is accepted.
  task automatic run_dump(input string tag, input bit v, input int s, input int clear_at);
    logic [7:0] exp_b[$];
    in_valid = v;
    drive_sample(s);
    dump  = 1'b1;
    clear = 1'b0;
    step();
    if (v) m_xfer(s);
    for (int i = 0; i < NB; i++) exp_b.push_back(8'(m_acc >> (8 * i)));
    exp_b.push_back(8'(m_cnt));
    dump     = 1'b0;
    in_valid = 1'b1;
    drive_sample(9'h1FF);
    for (int k = 0; k <= NB; k++) begin
      if (k > 0) begin
        clear = (k == clear_at);
        step();
        if (clear) m_clear();
        clear = 1'b0;
      end
      check($sformatf("%s.valid%0d", tag, k), 32'(out_valid), 32'd1);
      check($sformatf("%s.byte%0d", tag, k), 32'(out_byte), 32'(exp_b[k]));
      check($sformatf("%s.last%0d", tag, k), 32'(out_last), 32'(k == NB));
      check($sformatf("%s.ready%0d", tag, k), 32'(in_ready), 32'd0);
    end
    step();
    in_valid = 1'b0;
    check({tag, ".end_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".end_last"}, 32'(out_last), 32'd0);
    check({tag, ".end_ready"}, 32'(in_ready), 32'd1);
    check_totals({tag, ".end"});
  endtask

  initial begin
    // Reset state
    #2;
    check("rst.ready", 32'(in_ready), 32'd1);
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.last", 32'(out_last), 32'd0);
    check("rst.byte", 32'(out_byte), 32'd0);
    check_totals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single sample 0x135, then dump -> 35 01 01
    accum(1'b1, 9'h135, 1'b0);
    check_totals("one");
    run_dump("one", 1'b0, 0, 0);
    accum(1'b0, 0, 1'b1);
    check_totals("clr1");

    // 256 back-to-back 0x1FF samples: count saturates, acc wraps or clamps
    in_valid = 1'b1;
    drive_sample(9'h1FF);
    for (int i = 0; i < 256; i++) begin
      step();
      m_xfer(9'h1FF);
    end
    in_valid = 1'b0;
    check("sat.cnt_ff", 32'(sample_cnt), 32'hFF);
    check_totals("sat");
    run_dump("sat", 1'b0, 0, 0);
    accum(1'b0, 0, 1'b1);
    check_totals("clr2");

    // Dump with a same-cycle transfer of 0x010 from acc=0x0020
    accum(1'b1, 9'h020, 1'b0);
    run_dump("dxfer", 1'b1, 9'h010, 0);
    accum(1'b0, 0, 1'b1);

    // Clear during the second dump cycle: stream intact, live totals zeroed
    for (int i = 0; i < 5; i++) accum(1'b1, int'($urandom_range(511)), 1'b0);
    check_totals("pre_mid_clr");
    run_dump("midclr", 1'b0, 0, 2);
    run_dump("after_midclr", 1'b0, 0, 0);

    // clear and dump together in ACCUM: clear wins, no stream
    accum(1'b1, 9'h0AB, 1'b0);
    accum(1'b1, 9'h1C3, 1'b0);
    in_valid = 1'b1;
    drive_sample(9'h077);
    clear = 1'b1;
    dump  = 1'b1;
    step();
    m_clear();
    clear    = 1'b0;
    dump     = 1'b0;
    in_valid = 1'b0;
    check("cd.valid", 32'(out_valid), 32'd0);
    check("cd.ready", 32'(in_ready), 32'd1);
    check_totals("cd");
    step();
    check("cd.valid2", 32'(out_valid), 32'd0);

    // Randomized traffic with occasional clears, each round ending in a dump
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 24; c++) begin
        accum(1'($urandom_range(1)), int'($urandom_range(511)), ($urandom_range(15) == 0));
        check_totals($sformatf("rnd%0d.c%0d", r, c));
      end
      run_dump($sformatf("rnd%0d", r), 1'($urandom_range(1)), int'($urandom_range(511)),
               int'($urandom_range(NB + 1)));
    end

    // Drive into overflow, then reset in the second byte cycle of a dump
    in_valid = 1'b1;
    drive_sample(9'h1FF);
    for (int i = 0; i < 130; i++) begin
      step();
      m_xfer(9'h1FF);
    end
    in_valid = 1'b0;
    check_totals("preRst");
    dump = 1'b1;
    step();
    dump = 1'b0;
    step();
    check("rstdump.valid_before", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    m_clear();
    check("rstdump.valid", 32'(out_valid), 32'd0);
    check("rstdump.last", 32'(out_last), 32'd0);
    check("rstdump.ready", 32'(in_ready), 32'd1);
    #3;
    rst_n = 1'b1;
    step();
    check("rstdump.post_ready", 32'(in_ready), 32'd1);
    check("rstdump.post_valid", 32'(out_valid), 32'd0);
    check_totals("rstdump.post");
    step();
    check("rstdump.post_valid2", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
